// File: rtl/display_segundos.sv
`default_nettype none
// ============================================================================
// Module      : display_segundos
// Description : Converts a binary seconds value to 4-digit BCD with a
//               sequential double-dabble FSM (one shift per clock) and
//               drives a time-multiplexed, active-low 4-digit 7-segment
//               display.
// Ports       : clk      - system clock, rising edge
//               rst_n    - asynchronous active-low reset
//               segundos - binary seconds from the counter [W-1:0]
//               seg      - {g,f,e,d,c,b,a}, active-low
//               an       - digit enables, active-low, an[0] = units
//               bcd      - converted value, [3:0] = units
//               busy     - high while a conversion is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module display_segundos #(
  parameter int W          = 14,
  parameter int CLK_HZ     = 50_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLANK      = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] segundos,
  output logic [6:0]   seg,
  output logic [3:0]   an,
  output logic [15:0]  bcd,
  output logic         busy
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(W + 1);
  localparam int SW  = 16 + W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [13:0]     r_sample;
  logic [SW-1:0]   r_sh;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_bcd;
  logic            r_busy;
  logic [PW-1:0]   r_pre;
  logic [1:0]      r_idx;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;

  logic [13:0]     w_ext;
  logic [13:0]     w_clamp;
  logic [SW-1:0]   w_adj;
  logic [3:0]      w_nib;
  logic            w_blank;
  logic [6:0]      w_seg_nxt;

  // The stored sample holds the clamped value, so comparing the clamped input
  // keeps an out-of-range input held steady from re-triggering conversions.
  assign w_ext   = 14'(segundos);
  assign w_clamp = (w_ext > 14'd9999) ? 14'd9999 : w_ext;

  // Double-dabble correction: add 3 to every BCD nibble that is >= 5.
  always_comb begin
    w_adj = r_sh;
    for (int k = 0; k < 4; k++) begin
      if (r_sh[W+4*k +: 4] >= 4'd5) begin
        w_adj[W+4*k +: 4] = r_sh[W+4*k +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sample <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_bcd    <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_clamp != r_sample) begin
            r_sample <= w_clamp;
            r_sh     <= {16'd0, w_clamp[W-1:0]};
            r_cnt    <= CW'(W);
            r_busy   <= 1'b1;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sh  <= {w_adj[SW-2:0], 1'b0};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_bcd   <= r_sh[SW-1:W];
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Nibble selected by the scan index, plus leading-zero blanking
  always_comb begin
    w_nib   = r_bcd[3:0];
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib   = r_bcd[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_nib   = r_bcd[7:4];
        w_blank = (r_bcd[15:4] == 12'd0);
      end
      2'd2: begin
        w_nib   = r_bcd[11:8];
        w_blank = (r_bcd[15:8] == 8'd0);
      end
      default: begin
        w_nib   = r_bcd[15:12];
        w_blank = (r_bcd[15:12] == 4'd0);
      end
    endcase
  end

  always_comb begin
    w_seg_nxt = 7'h7F;
    case (w_nib)
      4'd0: w_seg_nxt = 7'b1000000;
      4'd1: w_seg_nxt = 7'b1111001;
      4'd2: w_seg_nxt = 7'b0100100;
      4'd3: w_seg_nxt = 7'b0110000;
      4'd4: w_seg_nxt = 7'b0011001;
      4'd5: w_seg_nxt = 7'b0010010;
      4'd6: w_seg_nxt = 7'b0000010;
      4'd7: w_seg_nxt = 7'b1111000;
      4'd8: w_seg_nxt = 7'b0000000;
      4'd9: w_seg_nxt = 7'b0010000;
      default: w_seg_nxt = 7'h7F;
    endcase
    if ((BLANK != 0) && w_blank) begin
      w_seg_nxt = 7'h7F;
    end
  end

  // Scan: prescaler wrap advances the digit; an/seg follow one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= 2'd0;
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end else begin
      if (r_pre == PW'(DIV - 1)) begin
        r_pre <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg_nxt;
    end
  end

  assign seg  = r_seg;
  assign an   = r_an;
  assign bcd  = r_bcd;
  assign busy = r_busy;

endmodule
`default_nettype wire
